beat_hit_judge: RTL and testbench
=================================

// Module: beat_hit_judge
// PURPOSE
//   Upstream stage of the hit-count/decoder block: turns a raw, bouncing player button into
//   the single-cycle "niceplay" hit pulse that stage registers and counts.
//   Synchronises and debounces the button, detects presses, judges each press against a timing
//   window opened by a beat tick, and emits hit/miss pulses plus a consecutive-hit streak.
// PARAMETERS
//   DEBOUNCE  4  cycles btn_sync must differ from btn_level before btn_level flips (1..255)
//   WINDOW    8  cycles a beat's hit window stays open, beat cycle included (1..255)
// PORTS
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  reset, asynchronous, active-high
//   btn_raw    in   1  raw asynchronous player button, active-high
//   beat       in   1  one-cycle beat tick, synchronous to clk
//   niceplay   out  1  registered one-cycle hit pulse (feeds the hit-count stage)
//   miss       out  1  registered one-cycle miss pulse
//   btn_level  out  1  debounced button level
//   streak     out  8  consecutive hits, saturating
//   win_open   out  1  high while FSM is in WINDOW
// BEHAVIOUR
//   Reset: all flops 0; niceplay=0, miss=0, btn_level=0, streak=0, win_open=0, state=IDLE.
//   rst mid-window or mid-debounce discards everything; no pulse on release of rst.
//   Sync: two-flop synchroniser btn_raw->btn_sync (2 cycles latency).
//   Debounce: 8-bit db_cnt; btn_sync==btn_level -> db_cnt=0; else db_cnt+1, and when
//     db_cnt==DEBOUNCE-1 btn_level<=btn_sync, db_cnt<=0. Glitch shorter than DEBOUNCE: no change.
//   press = btn_level & ~btn_level_d (combinational, one cycle per debounced rising edge).
//   Release (falling edge) never generates any pulse.
//   FSM, 8-bit win_cnt; hit/miss decided in cycle N appear on niceplay/miss in cycle N+1:
//     IDLE/DONE: beat&press -> hit, DONE. beat -> WINDOW, win_cnt=0.
//                press (no beat) -> miss, stay (early/extra press).
//     WINDOW: press (with or without beat) -> hit; next DONE, or WINDOW/win_cnt=0 if beat.
//             beat, no press -> miss (previous beat unanswered), WINDOW, win_cnt=0.
//             win_cnt==WINDOW-1, no press/beat -> miss, IDLE. else win_cnt+1.
//   Press on last window cycle is a hit (press beats timeout). hit and miss never both in a cycle.
//   Unused state encoding -> IDLE next cycle, no pulse.
//   streak: on hit streak<=streak+1, saturates at 255; on miss streak<=0; else hold.
//     Updates same edge as niceplay/miss.
//   niceplay high exactly one cycle per hit; back-to-back hits allowed (beat+press every cycle).
//   win_open = (state==WINDOW), registered with state.
// TESTING (DEBOUNCE=4, WINDOW=8)
//   Debounce: btn_raw 1 for 3 cycles then 0 -> btn_level stays 0; held 10 cycles -> btn_level
//     rises 2+4=6 cycles after btn_raw, one press.
//   Hit: beat at t0, press at t0+3 -> niceplay=1 at t0+4 only, miss=0, streak 0->1, DONE.
//   Timeout: beat, no press -> miss=1 one cycle after 8th window cycle, streak=0, IDLE.
//   Extra press: hit then second press before next beat -> miss pulse, streak=0.
//   Boundary: press on window cycle 7 -> hit; beat in WINDOW without press -> miss, window restarts.
//   Saturation/reset: 300 consecutive hits -> streak=255; assert rst mid-window -> all outputs 0.

Source files
------------

// File: rtl/beat_hit_judge.sv
// beat_hit_judge
//   Turns a raw, bouncing player button into judged hit/miss pulses.
//   First the button is synchronised and debounced. Each debounced rising
//   edge counts as one press. A beat tick opens a timing window, and every
//   press is judged against the window state.
//
//   Ports:
//     clk        clock, all state updates on the rising edge
//     rst        asynchronous active-high reset
//     btn_raw    raw asynchronous button, active-high
//     beat       one-cycle beat tick, synchronous to clk
//     niceplay   registered one-cycle hit pulse
//     miss       registered one-cycle miss pulse
//     btn_level  debounced button level
//     streak     consecutive hits, saturating at 255
//     win_open   high while the judge is in the WINDOW state
module beat_hit_judge #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned WINDOW   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       beat,
    output logic       niceplay,
    output logic       miss,
    output logic       btn_level,
    output logic [7:0] streak,
    output logic       win_open
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW_ST = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state, state_next;
    logic       btn_meta, btn_sync, btn_level_d;
    logic [7:0] db_cnt;
    logic [7:0] win_cnt, win_cnt_next;
    logic       press, hit, miss_c;

    // Two-flop synchroniser followed by the debounce counter.
    // btn_level only flips after btn_sync has disagreed with it for DEBOUNCE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_level   <= 1'b0;
            btn_level_d <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_meta    <= btn_raw;
            btn_sync    <= btn_meta;
            btn_level_d <= btn_level;
            if (btn_sync == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == 8'(DEBOUNCE - 1)) begin
                btn_level <= btn_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    // A release (falling edge) never produces a press.
    assign press = btn_level & ~btn_level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            niceplay <= 1'b0;
            miss     <= 1'b0;
            streak   <= '0;
        end else begin
            state    <= state_next;
            win_cnt  <= win_cnt_next;
            niceplay <= hit;
            miss     <= miss_c;
            if (hit) begin
                if (streak != 8'hFF) streak <= streak + 8'd1;
            end else if (miss_c) begin
                streak <= '0;
            end
        end
    end

    always_comb begin
        state_next   = state;
        win_cnt_next = win_cnt;
        hit          = 1'b0;
        miss_c       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (beat && press) begin
                    hit        = 1'b1;
                    state_next = DONE;
                end else if (beat) begin
                    state_next   = WINDOW_ST;
                    win_cnt_next = '0;
                end else if (press) begin
                    miss_c = 1'b1;
                end
            end
            WINDOW_ST: begin
                // A press takes priority over both a new beat and the timeout.
                if (press) begin
                    hit = 1'b1;
                    if (beat) begin
                        state_next   = WINDOW_ST;
                        win_cnt_next = '0;
                    end else begin
                        state_next = DONE;
                    end
                end else if (beat) begin
                    miss_c       = 1'b1;
                    win_cnt_next = '0;
                end else if (win_cnt == 8'(WINDOW - 1)) begin
                    miss_c     = 1'b1;
                    state_next = IDLE;
                end else begin
                    win_cnt_next = win_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign win_open = (state == WINDOW_ST);

endmodule

// File: tb/tb_beat_hit_judge.sv
module tb_beat_hit_judge;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       beat;
    logic       niceplay;
    logic       miss;
    logic       btn_level;
    logic [7:0] streak;
    logic       win_open;

    int vectors = 0;
    int errors  = 0;

    beat_hit_judge #(.DEBOUNCE(4), .WINDOW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .beat      (beat),
        .niceplay  (niceplay),
        .miss      (miss),
        .btn_level (btn_level),
        .streak    (streak),
        .win_open  (win_open)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Begin cycle: inputs set at the negedge are sampled at the next posedge.
    // Outputs seen right after are those produced by the previous posedge.
    task automatic cyc(input logic b, input logic r);
        @(negedge clk);
        beat    = b;
        btn_raw = r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === 32'(exp))
        else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".np"}, 32'(niceplay), 0);
        chk({tag, ".ms"}, 32'(miss), 0);
        chk({tag, ".lv"}, 32'(btn_level), 0);
        chk({tag, ".st"}, 32'(streak), 0);
        chk({tag, ".wo"}, 32'(win_open), 0);
    endtask

    initial begin
        rst     = 1'b1;
        beat    = 1'b0;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("RST");
        rst = 1'b0;

        // Glitch of 3 cycles never reaches btn_level
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, i < 3);
            chk($sformatf("A.lv[%0d]", i), 32'(btn_level), 0);
            chk($sformatf("A.ms[%0d]", i), 32'(miss), 0);
        end

        // Held button: level rises 6 cycles later; one early press -> one miss
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, i < 10);
            chk($sformatf("B.lv[%0d]", i), 32'(btn_level), (i >= 6) ? 1 : 0);
            chk($sformatf("B.ms[%0d]", i), 32'(miss), (i == 7) ? 1 : 0);
            chk($sformatf("B.np[%0d]", i), 32'(niceplay), 0);
        end
        repeat (3) cyc(1'b0, 1'b0);

        // Hit: beat at 3, press at 6 -> niceplay at 7
        for (int i = 0; i < 20; i++) begin
            cyc(i == 3, i < 9);
            chk($sformatf("C.wo[%0d]", i), 32'(win_open), (i >= 4 && i <= 6) ? 1 : 0);
            chk($sformatf("C.np[%0d]", i), 32'(niceplay), (i == 7) ? 1 : 0);
            chk($sformatf("C.ms[%0d]", i), 32'(miss), 0);
            chk($sformatf("C.st[%0d]", i), 32'(streak), (i >= 7) ? 1 : 0);
        end

        // Extra press in DONE without beat -> miss, streak cleared
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, i < 8);
            chk($sformatf("D.ms[%0d]", i), 32'(miss), (i == 7) ? 1 : 0);
            chk($sformatf("D.np[%0d]", i), 32'(niceplay), 0);
            chk($sformatf("D.st[%0d]", i), 32'(streak), (i >= 7) ? 0 : 1);
        end

        // Press on the last window cycle (win_cnt==7 at cycle 11) is a hit
        for (int i = 0; i < 22; i++) begin
            cyc(i == 3, i >= 5 && i < 13);
            chk($sformatf("F.wo[%0d]", i), 32'(win_open), (i >= 4 && i <= 11) ? 1 : 0);
            chk($sformatf("F.np[%0d]", i), 32'(niceplay), (i == 12) ? 1 : 0);
            chk($sformatf("F.ms[%0d]", i), 32'(miss), 0);
            chk($sformatf("F.st[%0d]", i), 32'(streak), (i >= 12) ? 1 : 0);
        end

        // Beat in WINDOW without press -> miss and window restarts; later press hits
        for (int i = 0; i < 22; i++) begin
            cyc(i == 0 || i == 4, i >= 4 && i < 12);
            chk($sformatf("G.wo[%0d]", i), 32'(win_open), (i >= 1 && i <= 10) ? 1 : 0);
            chk($sformatf("G.ms[%0d]", i), 32'(miss), (i == 5) ? 1 : 0);
            chk($sformatf("G.np[%0d]", i), 32'(niceplay), (i == 11) ? 1 : 0);
            chk($sformatf("G.st[%0d]", i), 32'(streak), (i < 5 || i >= 11) ? 1 : 0);
        end

        // Timeout: beat with no press -> miss one cycle after 8th window cycle
        for (int i = 0; i < 12; i++) begin
            cyc(i == 0, 1'b0);
            chk($sformatf("E.wo[%0d]", i), 32'(win_open), (i >= 1 && i <= 8) ? 1 : 0);
            chk($sformatf("E.ms[%0d]", i), 32'(miss), (i == 9) ? 1 : 0);
            chk($sformatf("E.st[%0d]", i), 32'(streak), (i >= 9) ? 0 : 1);
        end

        // Press together with beat inside WINDOW -> hit and window restarts
        for (int i = 0; i < 18; i++) begin
            cyc(i == 0 || i == 6, i < 7);
            chk($sformatf("H.wo[%0d]", i), 32'(win_open), (i >= 1 && i <= 14) ? 1 : 0);
            chk($sformatf("H.np[%0d]", i), 32'(niceplay), (i == 7) ? 1 : 0);
            chk($sformatf("H.ms[%0d]", i), 32'(miss), (i == 15) ? 1 : 0);
            chk($sformatf("H.st[%0d]", i), 32'(streak), (i >= 7 && i <= 14) ? 1 : 0);
        end

        // 300 consecutive beat+press hits -> streak saturates at 255
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 14; i++) begin
                cyc(i == 6, i < 7);
                chk("SAT.np", 32'(niceplay), (i == 7) ? 1 : 0);
                if (i == 13) chk($sformatf("SAT.st[%0d]", k), 32'(streak), (k >= 254) ? 255 : k + 1);
            end
        end

        // Reset in the middle of a window and a debounce
        cyc(1'b1, 1'b1);
        for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1);
        chk("RW.wo", 32'(win_open), 1);
        chk("RW.st", 32'(streak), 255);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("RW.async");
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0);
            chk_all_zero($sformatf("RW.post[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
